// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5..9 data bits, none/odd/even parity, 1-2 stop bits)
// with a valid/ready word input and a registered serial output.
module uart_tx_cfg #(
    parameter int CLK_HZ    = 125_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 UART_TX
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;

    if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d, tx_q, tx_d, done_q, done_d, en_q;
    logic                 tick, last, accept;

    // en_q keeps data_ready low until the first clock after reset release
    assign tick       = cnt_q == '0;
    assign last       = state_q == STOP && tick && idx_q == 4'(STOP_BITS - 1);
    assign data_ready = en_q && (state_q == IDLE || last);
    assign accept     = data_valid && data_ready;
    assign busy       = state_q != IDLE;
    assign tx_done    = done_q;
    assign UART_TX    = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? CW'(CPB - 1) : cnt_q - 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = last;
        case (state_q)
            IDLE: cnt_d = '0;
            START: if (tick) begin
                state_d = DATA;
                tx_d    = sh_q[0];
            end
            DATA: if (tick) begin
                sh_d = sh_q >> 1;
                if (idx_q == 4'(DATA_BITS - 1)) begin
                    idx_d   = '0;
                    state_d = (PARITY != 0) ? PAR : STOP;
                    tx_d    = (PARITY != 0) ? par_q : 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    tx_d  = sh_q[1];
                end
            end
            PAR: if (tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (tick) begin
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // an accept in the final stop cycle overrides the return to IDLE
        if (accept) begin
            state_d = START;
            cnt_d   = CW'(CPB - 1);
            idx_d   = '0;
            sh_d    = data_in;
            par_d   = ^data_in ^ (PARITY == 1);
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            en_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four transmitter configurations (8N1, 7O1, 7E1, 8N2 at 10 clk/bit) share one
// randomized producer; each is checked every cycle against a frame-timeline model.
module tb_uart_tx_cfg;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [8:0] din = '0;
    logic [3:0] tx, bsy, rdy, dno;
    logic [3:0] e_tx, e_bsy, e_rdy, e_dn;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] a5 = 10'b1101001010;

    always #5 clk = ~clk;

    function automatic int cfg_d(input int i);
        return (i == 1 || i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_p(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction
    function automatic int cfg_s(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_u
        localparam int D  = cfg_d(g);
        localparam int P  = cfg_p(g);
        localparam int S  = cfg_s(g);
        localparam int NB = 1 + D + ((P != 0) ? 1 : 0) + S;

        uart_tx_cfg #(.CLK_HZ(100), .BAUD(10), .DATA_BITS(D), .PARITY(P), .STOP_BITS(S)) u_dut (
            .sysclk(clk), .rst_n(rst_n), .data_in(din[D-1:0]), .data_valid(valid),
            .data_ready(rdy[g]), .busy(bsy[g]), .tx_done(dno[g]), .UART_TX(tx[g]));

        // frame as a bit list: start, data LSB first, optional parity, stop ones
        function automatic logic [15:0] frame(input logic [8:0] d);
            logic [15:0] f;
            int n;
            f    = '1;
            f[0] = 1'b0;
            n    = 0;
            for (int b = 0; b < D; b++) begin
                f[b+1] = d[b];
                n += int'(d[b]);
            end
            if (P == 1) f[D+1] = (n % 2 == 0);
            if (P == 2) f[D+1] = (n % 2 == 1);
            return f;
        endfunction

        int          per = 0;
        int          s = -1000000;
        int          dq = -1;
        int          pdq = -1;
        logic        en = 1'b0;
        logic [15:0] fr = '1;
        int          k;
        logic        inf, m_tx, m_bsy, m_rdy, m_dn;

        always_comb begin
            k     = per - s;
            inf   = k >= 0 && k < NB * CPB;
            m_bsy = inf;
            m_tx  = inf ? fr[k / CPB] : 1'b1;
            m_rdy = en && (!inf || k == NB * CPB - 1);
            m_dn  = per == dq || per == pdq;
        end

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s   <= -1000000;
                dq  <= -1;
                pdq <= -1;
                en  <= 1'b0;
            end else begin
                per <= per + 1;
                en  <= 1'b1;
                if (valid && m_rdy) begin
                    s   <= per + 1;
                    pdq <= dq;
                    dq  <= per + 1 + NB * CPB;
                    fr  <= frame(din);
                end
            end
        end

        assign e_tx[g]  = m_tx;
        assign e_bsy[g] = m_bsy;
        assign e_rdy[g] = m_rdy;
        assign e_dn[g]  = m_dn;
    end

    task automatic chk(input string nm, input int i, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] got %b want %b at %0t", nm, i, a, e, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("tx", i, tx[i], e_tx[i]);
            chk("busy", i, bsy[i], e_bsy[i]);
            chk("ready", i, rdy[i], e_rdy[i]);
            chk("done", i, dno[i], e_dn[i]);
        end
    endtask

    initial begin
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx", i, tx[i], 1'b1);
            chk("rst_busy", i, bsy[i], 1'b0);
            chk("rst_ready", i, rdy[i], 1'b0);
            chk("rst_done", i, dno[i], 1'b0);
        end
        rst_n = 1'b1;
        step();
        chk("ready_after_rel", 0, rdy[0], 1'b1);

        // 0xA5 on 8N1: fixed bit sequence and 100-cycle frame
        valid = 1'b1;
        din   = 9'h0A5;
        step();
        valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            repeat (5) step();
            chk("a5_bit", j, tx[0], a5[j]);
            repeat (j == 9 ? 4 : 5) step();
        end
        chk("a5_last_ready", 0, rdy[0], 1'b1);
        chk("a5_last_done", 0, dno[0], 1'b0);
        step();
        chk("a5_done", 0, dno[0], 1'b1);
        chk("a5_idle", 0, bsy[0], 1'b0);
        repeat (20) step();

        // 0x03 on 7O1 / 7E1: parity bit sampled mid-bit
        valid = 1'b1;
        din   = 9'h003;
        step();
        valid = 1'b0;
        repeat (85) step();
        chk("odd_par", 1, tx[1], 1'b1);
        chk("even_par", 2, tx[2], 1'b0);
        repeat (15) step();
        chk("par_done", 1, dno[1], 1'b1);
        chk("par_done", 2, dno[2], 1'b1);
        repeat (20) step();

        // back-to-back on 8N2 with data_valid held high
        valid = 1'b1;
        din   = 9'h055;
        step();
        din = 9'h00F;
        for (int c = 1; c <= 220; c++) begin
            step();
            if (c < 220) chk("b2b_busy", 3, bsy[3], 1'b1);
            if (c == 110 || c == 220) chk("b2b_done", 3, dno[3], 1'b1);
            if (c == 109 || c == 219) chk("b2b_nodone", 3, dno[3], 1'b0);
            if (c == 110) begin
                chk("b2b_start", 3, tx[3], 1'b0);
                valid = 1'b0;
            end
        end
        repeat (20) step();

        // reset in data bit 4 of a frame, then valid right after release
        valid = 1'b1;
        din   = 9'h03C;
        step();
        valid = 1'b0;
        repeat (52) step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("async_tx", i, tx[i], 1'b1);
            chk("async_busy", i, bsy[i], 1'b0);
            chk("async_ready", i, rdy[i], 1'b0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        valid = 1'b1;
        din   = 9'h081;
        step();
        chk("rel_ready", 0, rdy[0], 1'b1);
        chk("rel_tx", 0, tx[0], 1'b1);
        chk("rel_busy", 0, bsy[0], 1'b0);
        step();
        chk("rel_start", 0, tx[0], 1'b0);
        chk("rel_busy2", 0, bsy[0], 1'b1);
        valid = 1'b0;

        for (int n = 0; n < 4000; n++) begin
            step();
            valid = ($urandom_range(0, 2) == 0);
            din   = 9'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                repeat (2) step();
                rst_n = 1'b1;
            end
        end
        valid = 1'b0;
        repeat (150) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The module SHALL provide parameter CLK_HZ, default 125_000_000: sysclk frequency in Hz.
REQ-002 The module SHALL provide parameter BAUD, default 115_200: line rate in bit/s.
REQ-003 The module SHALL provide parameter DATA_BITS, default 8: payload width; legal range 5..9.
REQ-004 The module SHALL provide parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 The module SHALL provide parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-006 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-007 The module SHALL provide port `sysclk`, input, 1 bit: the clock; all state updates on its rising edge.
REQ-008 The module SHALL provide port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-009 The module SHALL provide port `data_in`, input, DATA_BITS wide: byte/word to send.
REQ-010 The module SHALL provide port `data_valid`, input, 1 bit: producer offers `data_in`.
REQ-011 The module SHALL provide port `data_ready`, output, 1 bit: transmitter can accept a word this cycle.
REQ-012 The module SHALL provide port `busy`, output, 1 bit: a frame is on the line.
REQ-013 The module SHALL provide port `tx_done`, output, 1 bit: single-cycle pulse at frame end.
REQ-014 The module SHALL provide port `UART_TX`, output, 1 bit: serial line, idle high.

Function
REQ-015 CLKS_PER_BIT SHALL equal CLK_HZ/BAUD (integer division); elaboration SHALL fail if it is < 2 or if DATA_BITS, PARITY or STOP_BITS is out of range.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
- IDLE -> START on accept.
- START -> DATA after 1 bit period.
- DATA -> PAR (PARITY != 0) or STOP after DATA_BITS periods.
- PAR -> STOP after 1 period.
- STOP -> IDLE after STOP_BITS periods.
REQ-017 A transfer SHALL be accepted when data_valid && data_ready are both high on a rising edge; `data_in` SHALL be captured into an internal shift register on that edge.
REQ-018 `data_ready` SHALL be high in IDLE and during the final clock cycle of the last stop bit; it SHALL be low otherwise.
REQ-019 The start bit (UART_TX = 0) SHALL begin on the cycle immediately after the accept edge (latency 1 clock).
REQ-020 Every line bit SHALL last exactly CLKS_PER_BIT cycles, counted by a bit-period counter that reloads at each bit boundary.
REQ-021 Data bits SHALL be sent LSB first.
REQ-022 The parity bit SHALL make the total count of ones (data plus parity) odd when PARITY = 1 and even when PARITY = 2.
REQ-023 Stop bits SHALL drive UART_TX = 1.
REQ-024 If a word is accepted in the final stop-bit cycle, its start bit SHALL follow with no idle gap (back-to-back frames).
REQ-025 `busy` SHALL be high from the cycle after accept until the last stop-bit cycle inclusive.
- Back-to-back frames: `busy` SHALL stay continuously high.
REQ-026 `tx_done` SHALL pulse high for exactly the cycle after the last stop-bit cycle, including the back-to-back case.
REQ-027 `data_in` and `data_valid` changes while not accepted SHALL NOT affect the frame in progress.
REQ-028 UART_TX SHALL be driven from a register (glitch-free).

Reset
REQ-029 On rst_n low, the following SHALL apply immediately, asynchronously:
- state = IDLE, counters = 0
- UART_TX = 1, busy = 0, tx_done = 0
- data_ready = 0 while rst_n is low, and 1 from the first clock after release.
REQ-030 Reset asserted mid-frame SHALL abort the frame; no partial bits SHALL resume after release.

Verification
REQ-031 Defaults overridden to CLK_HZ=100, BAUD=10 (10 clk/bit), 8N1; send 0xA5 -> UART_TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done after 100 cycles.
REQ-032 PARITY=1, DATA_BITS=7, send 0x03 -> parity bit 1; PARITY=2 same data -> parity bit 0; frame 100 cycles with 1 stop.
REQ-033 STOP_BITS=2, data_valid held high with 0x55 then 0x0F -> second start bit directly follows 20-cycle stop, busy never drops, two tx_done pulses 110 cycles apart.
REQ-034 rst_n pulsed low during bit 4 of a frame -> UART_TX = 1 asynchronously, busy = 0, no further low bits until a new accept.
REQ-035 data_valid pulsed during busy -> ignored (no accept, frame bits unchanged); data_valid at 1 cycle after rst_n release -> accepted.
